instr_fetch_axi: RTL

- Instruction fetch stage sitting directly upstream of the core control FSM and instruction register.
- On a fetch request it issues a single AXI4-Lite read for the current PC and captures the returned word.
- It presents the word to the instruction register with a one-cycle valid pulse, then advances the PC.
- It owns the program counter, supports a PC load (jump/boot vector) and flags bus errors.

---
 rtl/instr_fetch_axi_if.sv | 23 ++
 rtl/instr_fetch_axi.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_axi_if.sv
// AXI4-Lite read-channel bundle between the fetch stage (master) and the instruction memory (slave).
interface instr_fetch_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/instr_fetch_axi.sv
// Instruction fetch stage: one AXI4-Lite read per request, owns the PC,
// presents the fetched word with a one-cycle valid pulse and flags bus errors.
module instr_fetch_axi #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic                  pc_load,
  input  logic [ADDR_W-1:0]     pc_load_val,
  input  logic                  err_clr,
  output logic [ADDR_W-1:0]     pc,
  output logic [DATA_W-1:0]     instr,
  output logic                  instr_valid,
  output logic                  busy,
  output logic                  fetch_err,
  instr_fetch_axi_if.master     m_axi
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_val_q, pend_val_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      pend_q        <= 1'b0;
      pend_val_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    err_d         = err_q;
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    pend_d        = pend_q;
    pend_val_d    = pend_val_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    // A jump arriving mid-fetch is parked and applied once the fetch retires.
    if (state_q != S_IDLE && pc_load) begin
      pend_d     = 1'b1;
      pend_val_d = pc_load_val;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (fetch_req) begin
          araddr_d  = pc_q;
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (rready_q && m_axi.rvalid) begin
          instr_d       = m_axi.rdata;
          instr_valid_d = 1'b1;
          rready_d      = 1'b0;
          state_d       = S_DONE;
          if (m_axi.rresp != 2'b00) begin
            err_d = 1'b1;
          end else if (!(pend_q || pc_load)) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (pend_q) begin
          pc_d = pend_val_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign busy         = busy_q;
  assign fetch_err    = err_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule
